// File: rtl/gray_counter_param_pkg.sv
// Shared constants and types for the parametrised Gray counter family.
// Also imported by the future gray2bin and FIFO pointer logic.
package gray_counter_param_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int GRAY_MIN_WIDTH = 2;
    localparam int GRAY_MAX_WIDTH = 16;

    // What the counter register does on the coming edge, after Load/En priority.
    typedef enum logic [1:0] {
        STEP_HOLD,
        STEP_UP,
        STEP_DOWN,
        STEP_LOAD
    } step_e;

endpackage

// File: rtl/gray_counter_param_bin2gray.sv
// Pure combinational binary-to-Gray encoder.
// Adjacent binary values map to codes differing in one bit, including the MAX<->0 wrap.
module bin2gray #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter_param.sv
// Up/down binary counter with load, wrap/saturate mode and sticky boundary flags.
// The Gray output is encoded combinationally from the count register.
module gray_counter_param
    import gray_counter_param_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter bit SATURATE = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Dir,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             ClrFlags,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] BinOut,
    output logic             Overflow,
    output logic             Underflow,
    output logic             WrapPulse
);

    if (WIDTH < GRAY_MIN_WIDTH || WIDTH > GRAY_MAX_WIDTH) begin : g_bad_width
        $error("gray_counter_param: WIDTH must be in 2..16");
    end

    localparam logic [WIDTH-1:0] MAX_COUNT = '1;

    logic [WIDTH-1:0] count;
    step_e            step;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (count == MAX_COUNT);
    assign at_zero = (count == '0);

    always_comb begin
        step = STEP_HOLD;
        if (Load) begin
            step = STEP_LOAD;
        end else if (En) begin
            step = (Dir == DIR_UP) ? STEP_UP : STEP_DOWN;
        end
    end

    // ClrFlags is applied first so a boundary event on the same edge wins.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count     <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
            WrapPulse <= 1'b0;
        end else begin
            WrapPulse <= 1'b0;
            if (ClrFlags) begin
                Overflow  <= 1'b0;
                Underflow <= 1'b0;
            end
            case (step)
                STEP_LOAD: count <= LoadVal;
                STEP_UP: begin
                    if (at_max) begin
                        Overflow  <= 1'b1;
                        WrapPulse <= 1'b1;
                        count     <= SATURATE ? MAX_COUNT : '0;
                    end else begin
                        count <= count + WIDTH'(1);
                    end
                end
                STEP_DOWN: begin
                    if (at_zero) begin
                        Underflow <= 1'b1;
                        WrapPulse <= 1'b1;
                        count     <= SATURATE ? '0 : MAX_COUNT;
                    end else begin
                        count <= count - WIDTH'(1);
                    end
                end
                default: count <= count;
            endcase
        end
    end

    assign BinOut = count;

    bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
        .bin  (count),
        .gray (Output)
    );

endmodule

// File: tb/tb_gray_counter_param.sv
// Drives three counter configurations in lockstep and compares each against an
// integer-arithmetic model of the counting rules, plus a few fixed expected sequences.
module tb_gray_counter_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b1;
    logic       ld = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] lv = 8'd0;

    logic [2:0] out_a, bin_a, out_b, bin_b;
    logic [7:0] out_c, bin_c;
    logic       ovf_a, unf_a, wp_a, ovf_b, unf_b, wp_b, ovf_c, unf_c, wp_c;

    int checks = 0;
    int errors = 0;

    // Configurations: a = W3 wrap, b = W3 saturate, c = W8 wrap.
    int cfg_w[3] = '{3, 3, 8};
    int cfg_s[3] = '{0, 1, 0};
    int m_cnt[3];
    int m_ovf[3];
    int m_unf[3];
    int m_wp[3];

    always #5 clk = ~clk;

    gray_counter_param #(.WIDTH(3), .SATURATE(1'b0)) u_a (
        .Clk(clk), .Reset(rst), .En(en), .Dir(dir), .Load(ld), .LoadVal(lv[2:0]),
        .ClrFlags(clr), .Output(out_a), .BinOut(bin_a), .Overflow(ovf_a),
        .Underflow(unf_a), .WrapPulse(wp_a)
    );

    gray_counter_param #(.WIDTH(3), .SATURATE(1'b1)) u_b (
        .Clk(clk), .Reset(rst), .En(en), .Dir(dir), .Load(ld), .LoadVal(lv[2:0]),
        .ClrFlags(clr), .Output(out_b), .BinOut(bin_b), .Overflow(ovf_b),
        .Underflow(unf_b), .WrapPulse(wp_b)
    );

    gray_counter_param #(.WIDTH(8), .SATURATE(1'b0)) u_c (
        .Clk(clk), .Reset(rst), .En(en), .Dir(dir), .Load(ld), .LoadVal(lv),
        .ClrFlags(clr), .Output(out_c), .BinOut(bin_c), .Overflow(ovf_c),
        .Underflow(unf_c), .WrapPulse(wp_c)
    );

    function automatic int observed(int d, int k);
        logic [7:0] v [3][5];
        v[0] = '{8'(out_a), 8'(bin_a), 8'(ovf_a), 8'(unf_a), 8'(wp_a)};
        v[1] = '{8'(out_b), 8'(bin_b), 8'(ovf_b), 8'(unf_b), 8'(wp_b)};
        v[2] = '{out_c, bin_c, 8'(ovf_c), 8'(unf_c), 8'(wp_c)};
        return int'(v[d][k]);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model of one edge: plain integer step, out-of-range result is a boundary event.
    task automatic model_edge(input int d);
        int maxv;
        int nxt;
        maxv = (1 << cfg_w[d]) - 1;
        if (rst) begin
            m_cnt[d] = 0; m_ovf[d] = 0; m_unf[d] = 0; m_wp[d] = 0;
        end else begin
            m_wp[d] = 0;
            if (clr) begin
                m_ovf[d] = 0; m_unf[d] = 0;
            end
            if (ld) begin
                m_cnt[d] = int'(lv) % (maxv + 1);
            end else if (en) begin
                nxt = m_cnt[d] + (dir ? 1 : -1);
                if (nxt > maxv || nxt < 0) begin
                    m_wp[d] = 1;
                    if (nxt > maxv) m_ovf[d] = 1;
                    else m_unf[d] = 1;
                    if (cfg_s[d] == 0) m_cnt[d] = (nxt + maxv + 1) % (maxv + 1);
                end else begin
                    m_cnt[d] = nxt;
                end
            end
        end
    endtask

    task automatic check_output();
        string names[5] = '{"gray", "bin", "ovf", "unf", "wrap"};
        int exp[5];
        for (int d = 0; d < 3; d++) begin
            exp = '{m_cnt[d] ^ (m_cnt[d] >> 1), m_cnt[d], m_ovf[d], m_unf[d], m_wp[d]};
            for (int k = 0; k < 5; k++) begin
                check($sformatf("cfg%0d_%s", d, names[k]), observed(d, k), exp[k]);
            end
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic e, input logic dr,
                                  input logic l, input logic [7:0] v, input logic c);
        @(negedge clk);
        rst = r; en = e; dir = dr; ld = l; lv = v; clr = c;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) model_edge(d);
        check_output();
    endtask

    initial begin
        int seq[10] = '{0, 1, 3, 2, 6, 7, 5, 4, 0, 1};
        int r;

        $display("[TB] start");
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        check("reset_gray_w3", int'(out_a), 0);

        // Count up through the 3-bit wrap.
        for (int i = 1; i <= 9; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
            check($sformatf("seq_gray_%0d", i), int'(out_a), seq[i]);
            check($sformatf("seq_wrap_%0d", i), int'(wp_a), (i == 8) ? 1 : 0);
        end

        // Down from zero: wrap to MAX on cfg a, hold at 0 on cfg b.
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        check("down_bin_7", int'(bin_a), 7);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        check("down_gray_101", int'(out_a), 5);

        // Saturate at MAX for several cycles.
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'd7, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
            check($sformatf("sat_wrap_%0d", i), int'(wp_b), 1);
        end

        // Load beats enable.
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'd5, 1'b0);
        check("load_gray_111", int'(out_a), 7);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);

        // Flag set beats ClrFlags on the same edge, then clears.
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'd7, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'd7, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
        check("clr_set_wins", int'(ovf_a), 1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
        check("clr_done", int'(ovf_a), 0);

        // Reset mid-count on the 8-bit counter.
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'd200, 1'b0);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'd99, 1'b1);
        check("midreset_bin", int'(bin_c), 0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
        check("resume_bin", int'(bin_c), 1);

        // Randomised traffic, biased towards the boundaries.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            case ($urandom_range(0, 3))
                0: lv = 8'd0;
                1: lv = 8'd255;
                2: lv = 8'd7;
                default: lv = 8'($urandom);
            endcase
            apply_stimulus(r < 2, $urandom_range(0, 9) < 8, 1'($urandom),
                           $urandom_range(0, 9) == 0, lv, $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
